// File: rtl/f_bit_packer.sv
// f_bit_packer: samples a serial bit stream on qualified cycles, packs it into
// WORD_W-bit words and hands them out through a single valid/ready holding
// register. Partial words can be flushed. A sticky flag records dropped words.
module f_bit_packer #(
   parameter  int WORD_W    = 8,
   parameter  bit MSB_FIRST = 1'b0,
   localparam int LEN_W     = $clog2(WORD_W + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              f,
   input  logic              f_en,
   input  logic              flush,
   output logic [WORD_W-1:0] word,
   output logic [LEN_W-1:0]  word_len,
   output logic              word_valid,
   input  logic              word_ready,
   output logic              ovf,
   input  logic              ovf_clr
);

   localparam int CNT_W = $clog2(WORD_W);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t            state;
   logic [WORD_W-1:0] acc;
   logic [WORD_W-1:0] acc_nxt;
   logic [CNT_W-1:0]  bit_cnt;
   logic [CNT_W-1:0]  pos;
   logic [LEN_W-1:0]  cand_len;
   logic              cand_full;
   logic              cand_flush;
   logic              cand;

   // Accumulator including this cycle's bit, plus candidate-word detection.
   // acc_nxt is what gets loaded into the holding register on a candidate, so
   // a flush coinciding with f_en includes the bit being sampled.
   always_comb begin
      acc_nxt    = acc;
      pos        = MSB_FIRST ? (CNT_W'(WORD_W - 1) - bit_cnt) : bit_cnt;
      if (f_en) acc_nxt[pos] = f;
      cand_full  = f_en && (bit_cnt == CNT_W'(WORD_W - 1));
      cand_flush = flush && ((bit_cnt != '0) || f_en);
      cand       = cand_full || cand_flush;
      // Full word: bit_cnt is WORD_W-1 and f_en is 1, so this is WORD_W too.
      cand_len   = LEN_W'(bit_cnt) + LEN_W'(f_en);
   end

   // Bit accumulator: never stalls; a candidate always restarts it from zero.
   always_ff @(posedge clk) begin
      if (!rst) begin
         acc     <= '0;
         bit_cnt <= '0;
      end else if (cand) begin
         acc     <= '0;
         bit_cnt <= '0;
      end else if (f_en) begin
         acc     <= acc_nxt;
         bit_cnt <= bit_cnt + CNT_W'(1);
      end
   end

   // Holding register FSM with registered outputs and sticky overflow.
   // A candidate arriving while the register is held under backpressure is
   // dropped; ovf set wins over ovf_clr in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= EMPTY;
         word       <= '0;
         word_len   <= '0;
         word_valid <= 1'b0;
         ovf        <= 1'b0;
      end else begin
         case (state)
            EMPTY: begin
               if (cand) begin
                  word       <= acc_nxt;
                  word_len   <= cand_len;
                  word_valid <= 1'b1;
                  state      <= FULL;
               end
            end
            FULL: begin
               if (word_ready) begin
                  if (cand) begin
                     word     <= acc_nxt;
                     word_len <= cand_len;
                  end else begin
                     word_valid <= 1'b0;
                     state      <= EMPTY;
                  end
               end
            end
            default: begin
               word_valid <= 1'b0;
               state      <= EMPTY;
            end
         endcase

         if (state == FULL && !word_ready && cand) ovf <= 1'b1;
         else if (ovf_clr)                          ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_f_bit_packer.sv
// tb_f_bit_packer: directed stimulus for f_bit_packer (WORD_W=8, LSB first).
// Expected words go into a scoreboard queue; a monitor pops on each handshake.
module tb_f_bit_packer;

   localparam int WORD_W = 8;
   localparam int LEN_W  = $clog2(WORD_W + 1);

   typedef struct packed {
      logic [WORD_W-1:0] w;
      logic [LEN_W-1:0]  l;
   } exp_t;

   logic              clk;
   logic              rst;
   logic              f;
   logic              f_en;
   logic              flush;
   logic [WORD_W-1:0] word;
   logic [LEN_W-1:0]  word_len;
   logic              word_valid;
   logic              word_ready;
   logic              ovf;
   logic              ovf_clr;

   exp_t exp_q[$];
   int   hs_times[$];
   exp_t e_mon;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   f_bit_packer #(.WORD_W(WORD_W), .MSB_FIRST(1'b0)) dut (
      .clk        (clk),
      .rst        (rst),
      .f          (f),
      .f_en       (f_en),
      .flush      (flush),
      .word       (word),
      .word_len   (word_len),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .ovf        (ovf),
      .ovf_clr    (ovf_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every accepted word must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst && word_valid && word_ready) begin
         hs_times.push_back(cyc);
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_unexpected: got word %0h len %0d, expected no word", word, word_len);
         end else begin
            e_mon = exp_q.pop_front();
            chk("sb_word", 32'(word), 32'(e_mon.w));
            chk("sb_len", 32'(word_len), 32'(e_mon.l));
         end
      end
   end

   task automatic send_bit(input logic b);
      @(posedge clk); #1;
      f = b; f_en = 1'b1; flush = 1'b0;
   endtask

   task automatic send_word(input logic [WORD_W-1:0] w);
      for (int i = 0; i < WORD_W; i++) send_bit(w[i]);
   endtask

   task automatic idle();
      @(posedge clk); #1;
      f_en = 1'b0; flush = 1'b0; ovf_clr = 1'b0;
   endtask

   task automatic push(input logic [WORD_W-1:0] w, input int l);
      exp_t e;
      e.w = w;
      e.l = LEN_W'(l);
      exp_q.push_back(e);
   endtask

   initial begin
      rst = 1'b0; f = 1'b1; f_en = 1'b1; flush = 1'b0;
      word_ready = 1'b1; ovf_clr = 1'b0;

      // 1: reset with active input, then 8 bits are needed for a word
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(word_valid), 0);
      chk("rst_ovf", 32'(ovf), 0);
      chk("rst_len", 32'(word_len), 0);
      rst = 1'b1; f_en = 1'b0;
      for (int i = 0; i < 7; i++) send_bit(1'b1);
      idle();
      chk("t1_no_word_7bits", 32'(word_valid), 0);
      push(8'hFF, 8);
      send_bit(1'b1);
      idle();
      chk("t1_valid_8bits", 32'(word_valid), 1);
      idle();

      // 2: single word, 1-cycle valid pulse
      push(8'h8D, 8);
      send_word(8'h8D);
      idle();
      chk("t2_valid", 32'(word_valid), 1);
      chk("t2_word", 32'(word), 32'h8D);
      idle();
      chk("t2_valid_drop", 32'(word_valid), 0);

      // 3: backpressure drops the second word, ovf sticky and clearable
      word_ready = 1'b0;
      push(8'hA5, 8);
      send_word(8'hA5);
      send_word(8'h3C);
      idle();
      chk("t3_ovf_set", 32'(ovf), 1);
      chk("t3_word_held", 32'(word), 32'hA5);
      chk("t3_valid_held", 32'(word_valid), 1);
      @(posedge clk); #1; ovf_clr = 1'b1;
      idle();
      chk("t3_ovf_clr", 32'(ovf), 0);
      // set beats clear: flushed 1-bit word dropped with ovf_clr high
      send_bit(1'b1);
      @(posedge clk); #1; f_en = 1'b0; flush = 1'b1; ovf_clr = 1'b1;
      idle();
      chk("t3_ovf_set_prio", 32'(ovf), 1);
      chk("t3_word_still", 32'(word), 32'hA5);
      @(posedge clk); #1; ovf_clr = 1'b1;
      idle();
      chk("t3_ovf_clr2", 32'(ovf), 0);
      word_ready = 1'b1;
      idle();
      chk("t3_drained", 32'(word_valid), 0);

      // 4: 16 back-to-back bits -> two handshakes 8 cycles apart
      hs_times.delete();
      push(8'h5A, 8);
      push(8'hC3, 8);
      send_word(8'h5A);
      send_word(8'hC3);
      idle();
      idle();
      chk("t4_hs_count", hs_times.size(), 2);
      if (hs_times.size() == 2) chk("t4_hs_spacing", hs_times[1] - hs_times[0], 8);
      chk("t4_ovf", 32'(ovf), 0);

      // 5: flush of a partial word, then empty flush does nothing
      push(8'h03, 3);
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      @(posedge clk); #1; f_en = 1'b0; flush = 1'b1;
      idle();
      chk("t5_valid", 32'(word_valid), 1);
      chk("t5_len", 32'(word_len), 3);
      idle();
      chk("t5_valid_drop", 32'(word_valid), 0);
      @(posedge clk); #1; flush = 1'b1;
      idle();
      chk("t5_empty_flush", 32'(word_valid), 0);
      idle();
      chk("t5_empty_flush2", 32'(word_valid), 0);
      // flush together with f_en includes the sampled bit
      push(8'h03, 2);
      send_bit(1'b1);
      @(posedge clk); #1; f = 1'b1; f_en = 1'b1; flush = 1'b1;
      idle();
      chk("t5_flush_fen", 32'(word_valid), 1);
      idle();
      // full word and flush in the same cycle -> exactly one word
      push(8'h81, 8);
      for (int i = 0; i < 7; i++) send_bit(i == 0);
      @(posedge clk); #1; f = 1'b1; f_en = 1'b1; flush = 1'b1;
      idle();
      chk("t5_full_flush", 32'(word_valid), 1);
      chk("t5_full_flush_len", 32'(word_len), 8);
      idle();
      chk("t5_single_word", 32'(word_valid), 0);

      // 6: reset mid-word discards partial bits
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      @(posedge clk); #1; f_en = 1'b0; rst = 1'b0;
      @(posedge clk); #1; rst = 1'b1;
      chk("t6_rst_valid", 32'(word_valid), 0);
      push(8'hFF, 8);
      for (int i = 0; i < 8; i++) begin
         send_bit(1'b1);
         idle();
      end
      chk("t6_valid", 32'(word_valid), 1);
      chk("t6_word", 32'(word), 32'hFF);
      idle();
      chk("t6_valid_drop", 32'(word_valid), 0);

      repeat (3) idle();
      chk("sb_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
